// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter run-control sequencer.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        STALL,
        DONE
    } state_e;

    localparam logic [9:0] PROG_BASE0   = 10'd0;
    localparam logic [9:0] PROG_BASE1   = 10'd256;
    localparam logic [9:0] PROG_BASE2   = 10'd512;
    localparam logic [1:0] PROG_INVALID = 2'd3;

    function automatic logic [9:0] prog_base(input logic [1:0] sel);
        logic [9:0] base;
        case (sel)
            2'd1:    base = PROG_BASE1;
            2'd2:    base = PROG_BASE2;
            default: base = PROG_BASE0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Run-control sequencer: launches a stored program and steers the PC each cycle
// (increment, LUT jump, stall hold, halt), with run statistics.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int L  = 10,
    parameter int CW = 16,
    parameter int BW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          Flag,
    input  logic [L-3:0]  LutTarget,
    input  logic          StallReq,
    output logic          PcLoad,
    output logic          PcInc,
    output logic [L-1:0]  PcTarget,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] CycleCnt,
    output logic [BW-1:0] BranchCnt
);

    state_e     state_q, state_d;
    logic [1:0] prog_sel_q, prog_sel_d;
    logic       cyc_clr, cyc_inc;
    logic       br_clr, br_inc;

    // PC controls are decoded combinationally so the PC acts on this same edge.
    always_comb begin
        state_d    = state_q;
        prog_sel_d = prog_sel_q;
        PcLoad     = 1'b0;
        PcInc      = 1'b0;
        PcTarget   = '0;
        cyc_clr    = 1'b0;
        cyc_inc    = 1'b0;
        br_clr     = 1'b0;
        br_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start && (ProgSel != PROG_INVALID)) begin
                    prog_sel_d = ProgSel;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                PcLoad   = 1'b1;
                PcTarget = L'(prog_base(prog_sel_q));
                cyc_clr  = 1'b1;
                br_clr   = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                cyc_inc = 1'b1;
                if (Halt) begin
                    state_d = DONE;
                end else if (StallReq) begin
                    state_d = STALL;
                end else if (BranchEn && Flag) begin
                    PcLoad   = 1'b1;
                    PcTarget = L'(LutTarget);
                    br_inc   = 1'b1;
                end else begin
                    PcInc = 1'b1;
                end
            end
            STALL: begin
                cyc_inc = 1'b1;
                if (!StallReq) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // Wait for Start to drop so a held request cannot relaunch.
                if (!Start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            prog_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            prog_sel_q <= prog_sel_d;
        end
    end

    assign Busy = (state_q == LAUNCH) || (state_q == RUN) || (state_q == STALL);
    assign Done = (state_q == DONE);

    sat_counter #(.W(CW)) u_cycle_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cyc_clr),
        .inc   (cyc_inc),
        .count (CycleCnt)
    );

    sat_counter #(.W(BW)) u_branch_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (br_clr),
        .inc   (br_inc),
        .count (BranchCnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a default-width instance and a narrow-counter instance
// driven together, checked every cycle against a behavioural run model.
module tb_pc_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [1:0] ProgSel;
    logic       Halt;
    logic       BranchEn;
    logic       Flag;
    logic [7:0] LutTarget;
    logic       StallReq;

    logic        PcLoad, PcInc, Busy, Done;
    logic [9:0]  PcTarget;
    logic [15:0] CycleCnt;
    logic [7:0]  BranchCnt;

    logic        PcLoad_s, PcInc_s, Busy_s, Done_s;
    logic [9:0]  PcTarget_s;
    logic [3:0]  CycleCnt_s;
    logic [1:0]  BranchCnt_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
        .BranchEn(BranchEn), .Flag(Flag), .LutTarget(LutTarget), .StallReq(StallReq),
        .PcLoad(PcLoad), .PcInc(PcInc), .PcTarget(PcTarget), .Busy(Busy), .Done(Done),
        .CycleCnt(CycleCnt), .BranchCnt(BranchCnt)
    );

    pc_sequencer #(.L(10), .CW(4), .BW(2)) dut_s (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .Halt(Halt),
        .BranchEn(BranchEn), .Flag(Flag), .LutTarget(LutTarget), .StallReq(StallReq),
        .PcLoad(PcLoad_s), .PcInc(PcInc_s), .PcTarget(PcTarget_s), .Busy(Busy_s), .Done(Done_s),
        .CycleCnt(CycleCnt_s), .BranchCnt(BranchCnt_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: run phase, selected program, counters and the PC it implies.
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_RUN = 2, P_STALL = 3, P_DONE = 4;
    int m_ph, m_sel, m_cyc, m_br, m_cyc_s, m_br_s, m_pc;
    int b_pc, b_pc_s;

    function automatic int sat_add(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_ph <= P_IDLE; m_sel <= 0; m_cyc <= 0; m_br <= 0;
            m_cyc_s <= 0; m_br_s <= 0; m_pc <= 0; b_pc <= 0; b_pc_s <= 0;
        end else begin
            b_pc   <= PcLoad   ? int'(PcTarget)   : (PcInc   ? (b_pc + 1) % 1024   : b_pc);
            b_pc_s <= PcLoad_s ? int'(PcTarget_s) : (PcInc_s ? (b_pc_s + 1) % 1024 : b_pc_s);
            case (m_ph)
                P_IDLE: if (Start && ProgSel != 2'd3) begin
                    m_ph <= P_LAUNCH; m_sel <= int'(ProgSel);
                end
                P_LAUNCH: begin
                    m_ph <= P_RUN; m_pc <= m_sel * 256;
                    m_cyc <= 0; m_br <= 0; m_cyc_s <= 0; m_br_s <= 0;
                end
                P_RUN: begin
                    m_cyc <= sat_add(m_cyc, 65535); m_cyc_s <= sat_add(m_cyc_s, 15);
                    if (Halt) m_ph <= P_DONE;
                    else if (StallReq) m_ph <= P_STALL;
                    else if (BranchEn && Flag) begin
                        m_pc <= int'(LutTarget);
                        m_br <= sat_add(m_br, 255); m_br_s <= sat_add(m_br_s, 3);
                    end else m_pc <= (m_pc + 1) % 1024;
                end
                P_STALL: begin
                    m_cyc <= sat_add(m_cyc, 65535); m_cyc_s <= sat_add(m_cyc_s, 15);
                    if (!StallReq) m_ph <= P_RUN;
                end
                default: if (!Start) m_ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge Clk) begin
        bit take, e_load, e_inc;
        int e_tgt;
        take   = (m_ph == P_RUN) && !Halt && !StallReq && BranchEn && Flag;
        e_load = (m_ph == P_LAUNCH) || take;
        e_inc  = (m_ph == P_RUN) && !Halt && !StallReq && !(BranchEn && Flag);
        e_tgt  = (m_ph == P_LAUNCH) ? m_sel * 256 : (take ? int'(LutTarget) : 0);
        chk("pc_load",    int'(PcLoad),    int'(e_load));
        chk("pc_inc",     int'(PcInc),     int'(e_inc));
        chk("pc_target",  int'(PcTarget),  e_tgt);
        chk("busy",       int'(Busy),      int'(m_ph == P_LAUNCH || m_ph == P_RUN || m_ph == P_STALL));
        chk("done",       int'(Done),      int'(m_ph == P_DONE));
        chk("cycle_cnt",  int'(CycleCnt),  m_cyc);
        chk("branch_cnt", int'(BranchCnt), m_br);
        chk("pc_value",   b_pc,            m_pc);
        chk("s_pc_value", b_pc_s,          m_pc);
        chk("s_cycle_cnt",  int'(CycleCnt_s),  m_cyc_s);
        chk("s_branch_cnt", int'(BranchCnt_s), m_br_s);
        chk("s_done",     int'(Done_s),    int'(m_ph == P_DONE));
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic peek();
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
        BranchEn = 1'b0; Flag = 1'b0; LutTarget = 8'h00; StallReq = 1'b0;
        repeat (2) step();
        Reset = 1'b1;
        repeat (2) step();
        peek(); chk("idle_busy", int'(Busy), 0);

        ProgSel = 2'd1; Start = 1'b1;
        step(); peek();
        chk("launch_load", int'(PcLoad), 1);
        chk("launch_tgt",  int'(PcTarget), 256);
        chk("launch_busy", int'(Busy), 1);
        step(); peek();
        chk("run_inc", int'(PcInc), 1);
        chk("run_cyc0", int'(CycleCnt), 0);
        step();
        BranchEn = 1'b1; Flag = 1'b1; LutTarget = 8'h2A;
        peek();
        chk("br_load", int'(PcLoad), 1);
        chk("br_tgt",  int'(PcTarget), 42);
        step();
        chk("br_cnt1", int'(BranchCnt), 1);
        Flag = 1'b0;
        peek(); chk("nbr_inc", int'(PcInc), 1);
        step();
        chk("nbr_cnt", int'(BranchCnt), 1);
        BranchEn = 1'b0;

        StallReq = 1'b1;
        step();
        Halt = 1'b1;
        step(); step();
        StallReq = 1'b0; Halt = 1'b0;
        step();
        chk("stall_cyc",  int'(CycleCnt), 7);
        chk("stall_busy", int'(Busy), 1);
        Halt = 1'b1;
        step(); Halt = 1'b0;
        chk("halt_done", int'(Done), 1);
        chk("halt_cyc",  int'(CycleCnt), 8);
        repeat (3) step();
        chk("hold_done", int'(Done), 1);
        Start = 1'b0;
        step();
        chk("release_done", int'(Done), 0);

        ProgSel = 2'd2; Start = 1'b1;
        step(); peek(); chk("launch2_tgt", int'(PcTarget), 512);
        step();
        repeat (9) step();
        Halt = 1'b1;
        step(); Halt = 1'b0;
        chk("ten_cyc", int'(CycleCnt), 10);
        chk("ten_done", int'(Done), 1);
        repeat (2) step();
        chk("ten_hold", int'(Done), 1);
        Start = 1'b0;
        step();

        ProgSel = 2'd0; Start = 1'b1;
        step(); step();
        repeat (19) step();
        Halt = 1'b1;
        step(); Halt = 1'b0;
        chk("twenty_cyc", int'(CycleCnt), 20);
        chk("sat_cyc",    int'(CycleCnt_s), 15);
        Start = 1'b0;
        step();

        ProgSel = 2'd3; Start = 1'b1;
        repeat (3) step();
        peek();
        chk("inv_busy", int'(Busy), 0);
        chk("inv_load", int'(PcLoad), 0);
        Start = 1'b0;
        step();

        ProgSel = 2'd1; Start = 1'b1;
        step(); step(); step();
        peek(); chk("pre_rst_inc", int'(PcInc), 1);
        step();
        Reset = 1'b0;
        #1;
        chk("rst_inc",  int'(PcInc), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_cyc",  int'(CycleCnt), 0);
        chk("rst_load", int'(PcLoad), 0);
        Start = 1'b0;
        step();
        Reset = 1'b1;
        repeat (2) step();
        peek(); chk("post_rst_idle", int'(Busy), 0);

        repeat (3000) begin
            step();
            Start     = ($urandom_range(0, 5) != 0);
            ProgSel   = 2'($urandom_range(0, 3));
            Halt      = ($urandom_range(0, 29) == 0);
            StallReq  = ($urandom_range(0, 7) == 0);
            BranchEn  = ($urandom_range(0, 3) == 0);
            Flag      = $urandom_range(0, 1) != 0;
            LutTarget = 8'($urandom_range(0, 255));
        end
        Start = 1'b0; Halt = 1'b0; StallReq = 1'b0; BranchEn = 1'b0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
